counter_scheduler: RTL and testbench

COUNTER_SCHEDULER -- requirements
Module: counter_scheduler

---
 rtl/counter_scheduler.sv | 148 ++++++++++++++
 tb/tb_counter_scheduler.sv | 229 ++++++++++++++++++++++
 2 files changed

// File: rtl/counter_scheduler.sv
// Round-robin load scheduler for four counter channels: arbitrates load requests,
// tracks armed channels, returns completions, and generates the shared decrement tick.
module counter_scheduler #(
  localparam int unsigned N_CH = 4,
  localparam int unsigned DW   = 32,
  localparam int unsigned PW   = 16
) (
  input  logic               sysclk,
  input  logic               foo_card,
  input  logic [N_CH-1:0]    req,
  input  logic [N_CH*DW-1:0] turn_bus,
  input  logic [PW-1:0]      presc_div,
  input  logic               abort,
  input  logic [N_CH-1:0]    cwm_in,
  output logic [N_CH-1:0]    grant,
  output logic [N_CH-1:0]    baz,
  output logic [DW-1:0]      turn_out,
  output logic               blrb,
  output logic [N_CH-1:0]    zz1pb,
  output logic [N_CH-1:0]    done,
  output logic [N_CH-1:0]    busy
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    LOAD  = 2'd1,
    FLUSH = 2'd2
  } state_e;

  state_e          state_q;
  logic [1:0]      ptr_q;
  logic [1:0]      sel_q;
  logic [N_CH-1:0] grant_q;
  logic [N_CH-1:0] baz_q;
  logic [DW-1:0]   turn_out_q;
  logic [N_CH-1:0] zz1pb_q;
  logic [N_CH-1:0] done_q;
  logic [N_CH-1:0] busy_q;
  logic [PW-1:0]   presc_cnt_q;
  logic [PW-1:0]   presc_cnt_d;
  logic            blrb_q;

  logic [N_CH-1:0] eligible_c;
  logic [1:0]      sel_c;
  logic [N_CH-1:0] sel_oh_c;
  logic [N_CH-1:0] load_oh_c;
  logic [N_CH-1:0] ack_c;
  logic            presc_hit_c;
  logic [DW-1:0]   slice_c [N_CH];

  for (genvar g = 0; g < N_CH; g++) begin : g_slice
    assign slice_c[g] = turn_bus[g*DW +: DW];
  end

  // Round-robin pick: first eligible requester at or after ptr_q.
  always_comb begin
    logic [1:0] idx;
    logic       found;
    idx        = '0;
    found      = 1'b0;
    sel_c      = '0;
    eligible_c = req & ~busy_q;
    for (int k = 0; k < N_CH; k++) begin
      idx = ptr_q + k[1:0];
      if (!found && eligible_c[idx]) begin
        sel_c = idx;
        found = 1'b1;
      end
    end
  end

  assign sel_oh_c  = N_CH'(1) << sel_c;
  assign load_oh_c = N_CH'(1) << sel_q;
  assign ack_c     = cwm_in & busy_q;

  // Scheduler FSM; completions are acknowledged in every state unless flushing.
  always_ff @(posedge sysclk or posedge foo_card) begin
    if (foo_card) begin
      state_q    <= IDLE;
      ptr_q      <= '0;
      sel_q      <= '0;
      grant_q    <= '0;
      baz_q      <= '0;
      turn_out_q <= '0;
      zz1pb_q    <= '1;
      done_q     <= '0;
      busy_q     <= '0;
    end else begin
      grant_q <= '0;
      baz_q   <= '0;
      done_q  <= ack_c;
      zz1pb_q <= ~ack_c;
      busy_q  <= busy_q & ~ack_c;
      if (abort) begin
        state_q <= FLUSH;
        busy_q  <= '0;
        zz1pb_q <= '0;
        done_q  <= '0;
      end else begin
        case (state_q)
          IDLE: begin
            if (|eligible_c) begin
              state_q    <= LOAD;
              grant_q    <= sel_oh_c;
              baz_q      <= sel_oh_c;
              turn_out_q <= slice_c[sel_c];
              sel_q      <= sel_c;
            end
          end
          LOAD: begin
            state_q <= IDLE;
            ptr_q   <= sel_q + 2'd1;
            // A zero load completes immediately instead of arming the channel.
            if (turn_out_q != '0) begin
              busy_q <= (busy_q & ~ack_c) | load_oh_c;
            end else begin
              done_q <= ack_c | load_oh_c;
            end
          end
          default: state_q <= IDLE;
        endcase
      end
    end
  end

  // Free-running prescaler; >= compare lets a lowered divider take effect at once.
  assign presc_hit_c = presc_cnt_q >= presc_div;
  assign presc_cnt_d = presc_hit_c ? '0 : presc_cnt_q + PW'(1);

  always_ff @(posedge sysclk or posedge foo_card) begin
    if (foo_card) begin
      presc_cnt_q <= '0;
      blrb_q      <= 1'b0;
    end else begin
      presc_cnt_q <= presc_cnt_d;
      blrb_q      <= presc_hit_c;
    end
  end

  assign grant    = grant_q;
  assign baz      = baz_q;
  assign turn_out = turn_out_q;
  assign blrb     = blrb_q;
  assign zz1pb    = zz1pb_q;
  assign done     = done_q;
  assign busy     = busy_q;

endmodule

// File: tb/tb_counter_scheduler.sv
// Directed-vector bench for counter_scheduler with hand-computed expectations.
module tb_counter_scheduler;

  logic         sysclk;
  logic         foo_card;
  logic [3:0]   req;
  logic [127:0] turn_bus;
  logic [15:0]  presc_div;
  logic         abort;
  logic [3:0]   cwm_in;
  logic [3:0]   grant;
  logic [3:0]   baz;
  logic [31:0]  turn_out;
  logic         blrb;
  logic [3:0]   zz1pb;
  logic [3:0]   done;
  logic [3:0]   busy;

  int n_vec;
  int n_err;

  counter_scheduler dut (
    .sysclk    (sysclk),
    .foo_card  (foo_card),
    .req       (req),
    .turn_bus  (turn_bus),
    .presc_div (presc_div),
    .abort     (abort),
    .cwm_in    (cwm_in),
    .grant     (grant),
    .baz       (baz),
    .turn_out  (turn_out),
    .blrb      (blrb),
    .zz1pb     (zz1pb),
    .done      (done),
    .busy      (busy)
  );

  initial sysclk = 1'b0;
  always #5 sysclk = ~sysclk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
    n_vec++;
    if (obs !== exp_v) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp_v);
    end
  endtask

  task automatic cyc();
    @(posedge sysclk);
    #1;
  endtask

  task automatic do_reset();
    foo_card  = 1'b1;
    req       = '0;
    abort     = 1'b0;
    cwm_in    = '0;
    turn_bus  = '0;
    presc_div = 16'hFFFF;
    cyc();
    cyc();
    chk("rst_grant", 32'(grant), 32'h0);
    chk("rst_baz", 32'(baz), 32'h0);
    chk("rst_turn", turn_out, 32'h0);
    chk("rst_blrb", 32'(blrb), 32'h0);
    chk("rst_zz1pb", 32'(zz1pb), 32'hF);
    chk("rst_done", 32'(done), 32'h0);
    chk("rst_busy", 32'(busy), 32'h0);
    foo_card = 1'b0;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end

  initial begin
    logic [3:0] exp_baz;
    n_vec = 0;
    n_err = 0;

    // Single load and completion
    do_reset();
    turn_bus = 128'd5;
    req      = 4'b0001;
    cyc();
    chk("single_grant", 32'(grant), 32'h1);
    chk("single_baz", 32'(baz), 32'h1);
    chk("single_turn", turn_out, 32'h5);
    cyc();
    req = '0;
    chk("single_baz_off", 32'(baz), 32'h0);
    chk("single_busy", 32'(busy), 32'h1);
    cyc();
    chk("single_busy_hold", 32'(busy), 32'h1);
    cwm_in = 4'b0001;
    cyc();
    cwm_in = '0;
    chk("single_zz1pb", 32'(zz1pb), 32'hE);
    chk("single_done", 32'(done), 32'h1);
    chk("single_busy_clr", 32'(busy), 32'h0);
    cyc();
    chk("single_done_off", 32'(done), 32'h0);
    chk("single_zz1pb_off", 32'(zz1pb), 32'hF);

    // Contention: baz on cycles 1,3,5,7 in round-robin order
    do_reset();
    turn_bus = {32'h44, 32'h33, 32'h22, 32'h11};
    req      = 4'b1111;
    for (int c = 1; c <= 8; c++) begin
      cyc();
      exp_baz = (c % 2 == 1) ? (4'b0001 << ((c - 1) / 2)) : 4'b0000;
      chk("rr_baz", 32'(baz), 32'(exp_baz));
      if (c % 2 == 1) chk("rr_turn", turn_out, 32'(32'h11 * ((c + 1) / 2)));
    end
    chk("rr_busy_all", 32'(busy), 32'hF);
    cyc();
    cyc();
    chk("rr_busy_ignored", 32'(baz), 32'h0);
    req    = '0;
    cwm_in = 4'b1010;
    cyc();
    chk("ack_a_done", 32'(done), 32'hA);
    chk("ack_a_busy", 32'(busy), 32'h5);
    cwm_in = 4'b0101;
    cyc();
    chk("ack_b_zz1pb", 32'(zz1pb), 32'hA);
    chk("ack_b_done", 32'(done), 32'h5);
    chk("ack_b_busy", 32'(busy), 32'h0);
    cyc();
    chk("ack_no_second_done", 32'(done), 32'h0);
    chk("ack_idle_zz1pb", 32'(zz1pb), 32'hF);
    cwm_in = '0;

    // Zero load on channel 2
    do_reset();
    turn_bus = {32'h7, 32'h0, 32'h9, 32'h3};
    req      = 4'b0100;
    cyc();
    chk("zero_baz", 32'(baz), 32'h4);
    chk("zero_turn", turn_out, 32'h0);
    cyc();
    req = '0;
    chk("zero_busy", 32'(busy), 32'h0);
    chk("zero_done", 32'(done), 32'h4);
    cyc();
    chk("zero_done_off", 32'(done), 32'h0);

    // Abort during LOAD with two channels armed, then abort held, then abort in IDLE
    do_reset();
    turn_bus = {32'h44, 32'h33, 32'h22, 32'h11};
    req      = 4'b0011;
    cyc();
    chk("ab_baz0", 32'(baz), 32'h1);
    cyc();
    req = 4'b0010;
    cyc();
    chk("ab_baz1", 32'(baz), 32'h2);
    cyc();
    req = 4'b0100;
    chk("ab_busy", 32'(busy), 32'h3);
    cyc();
    chk("ab_baz2", 32'(baz), 32'h4);
    abort = 1'b1;
    req   = '0;
    cyc();
    chk("flush_zz1pb", 32'(zz1pb), 32'h0);
    chk("flush_busy", 32'(busy), 32'h0);
    chk("flush_done", 32'(done), 32'h0);
    chk("flush_baz", 32'(baz), 32'h0);
    cyc();
    chk("flush_hold_zz1pb", 32'(zz1pb), 32'h0);
    abort = 1'b0;
    cyc();
    chk("flush_exit_zz1pb", 32'(zz1pb), 32'hF);
    req   = 4'b0001;
    abort = 1'b1;
    cyc();
    chk("abort_idle_baz", 32'(baz), 32'h0);
    chk("abort_idle_zz1pb", 32'(zz1pb), 32'h0);
    abort = 1'b0;
    req   = '0;
    cyc();
    chk("abort_idle_exit", 32'(zz1pb), 32'hF);

    // Reset asserted mid-LOAD clears outputs immediately
    req = 4'b0001;
    cyc();
    chk("midload_baz", 32'(baz), 32'h1);
    foo_card = 1'b1;
    #1;
    chk("midrst_baz", 32'(baz), 32'h0);
    chk("midrst_grant", 32'(grant), 32'h0);
    chk("midrst_turn", turn_out, 32'h0);
    chk("midrst_zz1pb", 32'(zz1pb), 32'hF);
    chk("midrst_busy", 32'(busy), 32'h0);
    req = '0;
    cyc();
    foo_card = 1'b0;

    // Prescaler: divider 3, then 0, then lowered mid-count
    do_reset();
    presc_div = 16'd3;
    for (int i = 1; i <= 12; i++) begin
      cyc();
      chk("blrb_div3", 32'(blrb), (i % 4 == 0) ? 32'h1 : 32'h0);
    end
    presc_div = 16'd0;
    for (int i = 0; i < 4; i++) begin
      cyc();
      chk("blrb_div0", 32'(blrb), 32'h1);
    end
    presc_div = 16'd100;
    for (int i = 0; i < 10; i++) cyc();
    chk("blrb_div100", 32'(blrb), 32'h0);
    presc_div = 16'd5;
    cyc();
    chk("blrb_lowered", 32'(blrb), 32'h1);
    cyc();
    chk("blrb_lowered_next", 32'(blrb), 32'h0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
